cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle control sequencer for the 16-bit CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It handles memory wait-states with a req/ready handshake and a timeout. It supports run and single-step modes for board debug, and exposes its state for the 7-segment display.

Parameters:
TIMEOUT, 15, max cycles mem_req stays high without mem_ready before bus error (1..15)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
opcode  in  4  IR[15:12] of current instruction (valid from DECODE onward)
alu_zero  in  1  ALU zero flag, sampled in EXEC
mem_ready  in  1  memory handshake completion
run  in  1  level; 1 = free-run, 0 = pause at instruction boundary
step  in  1  level from switch; rising edge releases one instruction when paused
mem_req  out  1  memory access request
mem_we  out  1  1 = write (ST), valid with mem_req
addr_sel  out  1  0 = PC, 1 = ALU result drives memory address
ir_load  out  1  load IR from memory data
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= branch/jump target
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
alu_b_imm  out  1  ALU B operand = sign-extended imm
reg_we  out  1  register file write enable
wb_sel  out  1  0 = ALU, 1 = memory data
halted  out  1  sticky, set in HALT
illegal  out  1  sticky, undefined opcode decoded
bus_err  out  1  sticky, memory timeout
state_dbg  out  3  current state encoding
retired  out  CNT_W  instructions completed, wraps

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQ, 9 JMP, F HALT. A–E are illegal.
- States and state_dbg encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, PAUSE=6.
- Reset: state PAUSE, all outputs 0, sticky flags 0, retired 0, timeout counter 0, step-edge register 0.
- step edge = step & ~step_q. Register step_q every cycle, including in reset.
- PAUSE -> FETCH when run=1 or step edge.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - ir_load = mem_ready; this is the only Mealy output.
  - Stay until mem_ready, then -> DECODE.
- DECODE:
  - pc_inc=1 for exactly one cycle.
  - Illegal opcode: illegal<=1 -> HALT.
  - Otherwise -> EXEC.
- EXEC:
  - ALU ops set alu_op. ADDI uses ADD with alu_b_imm=1. LD/ST use ADD with alu_b_imm=1 (address).
  - BEQ uses SUB and pc_load=alu_zero.
  - JMP asserts pc_load=1.
  - HALT opcode -> HALT.
  - NOP, BEQ, JMP retire here.
  - R-type/ADDI -> WB. LD/ST -> MEM.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for ST.
  - Hold until mem_ready. LD -> WB; ST retires.
- WB: reg_we=1. wb_sel=1 for LD, else 0. Retires.
- Retire:
  - retired += 1, same edge as the transition out of the retiring state.
  - Next state = FETCH if run=1, else PAUSE.
  - HALT does not retire.
- Latency with mem_ready already high:
  - 4 cycles: R-type/ADDI, ST.
  - 5 cycles: LD.
  - 3 cycles: NOP, BEQ, JMP.
- Timeout:
  - A counter clears on entering FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: bus_err<=1 -> HALT, mem_req drops next cycle.
  - mem_ready on the same cycle as the count reaching TIMEOUT wins: no error.
- HALT: halted=1, all control outputs 0. Only rst exits.
- Step edge while run=1 is ignored. Step edge outside PAUSE is ignored, not queued.
- run dropping mid-instruction: the instruction completes, then -> PAUSE.
- rst asserted mid-instruction, including mid-handshake: all outputs 0 at the next edge, no retire counted.
- Outputs other than ir_load are Moore, decoded from state and opcode.

Test Plan:
- Reset, run=1, mem_ready=1, ADD: state_dbg 0,1,2,4,0. reg_we high 1 cycle in WB. retired=1 after 4 cycles.
- LD with mem_ready delayed 3 cycles in MEM: MEM held 4 cycles with addr_sel=1, mem_we=0. Then WB with wb_sel=1 and reg_we=1. Total 8 cycles.
- BEQ with alu_zero=1, then alu_zero=0: pc_load=1 in EXEC only for the first. pc_inc once per instruction. Each takes 3 cycles.
- run=0 after reset: stays at state_dbg=6. Each step rising edge executes exactly one NOP (retired +1) and returns to 6. A held step does not repeat.
- mem_ready held 0 in FETCH, TIMEOUT=15: bus_err=1 and state_dbg=5 after 15 wait cycles. A second variant with mem_ready on cycle 15 gives no error.
- Opcode 0xB: illegal=1, halted=1, retired unchanged. rst returns all outputs to 0 and state_dbg=6.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath enables and selects, and guards memory handshakes
// with a wait-state timeout.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FETCH  | read instruction at PC, load IR on mem_ready
//   DECODE | bump PC, reject undefined opcodes
//   EXEC   | drive ALU, resolve branches/jumps, retire NOP/BEQ/JMP
//   MEM    | data access at ALU-computed address, ST retires here
//   WB     | register file write from ALU or memory data
//   HALT   | terminal; all controls low, only rst leaves
//   PAUSE  | instruction boundary; waits for run or a step rising edge
module cpu_control_fsm #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    input  logic             run,
    input  logic             step,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [1:0]       alu_op,
    output logic             alu_b_imm,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_PAUSE  = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Wait-state timer counts down from TIMEOUT; expiry is the wait cycle
    // that finds it at 1, i.e. the TIMEOUT-th cycle without mem_ready.
    localparam logic [3:0] TMO_LOAD = 4'(TIMEOUT);

    state_t             state_q, state_d;
    logic               step_q, step_d;
    logic [3:0]         tmo_q, tmo_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               step_edge;
    logic               retire;

    assign step_edge = step & ~step_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign state_dbg = state_q;
    assign retired   = retired_q;

    // State register, sticky flags, wait timer and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PAUSE;
            step_q    <= step_d;
            tmo_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            tmo_q     <= tmo_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic and control decode from state and opcode.
    always_comb begin
        state_d   = state_q;
        step_d    = step;
        tmo_d     = tmo_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        retired_d = retired_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_op    = ALU_ADD;
        alu_b_imm = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;

        case (state_q)
            S_PAUSE: begin
                if (run || step_edge) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (tmo_q == 4'd1) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    tmo_d = tmo_q - 4'd1;
                end
            end
            S_DECODE: begin
                pc_inc = 1'b1;
                if (opcode <= OP_JMP || opcode == OP_HALT) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_NOP:  retire = 1'b1;
                    OP_ADD:  begin alu_op = ALU_ADD; state_d = S_WB; end
                    OP_SUB:  begin alu_op = ALU_SUB; state_d = S_WB; end
                    OP_AND:  begin alu_op = ALU_AND; state_d = S_WB; end
                    OP_OR:   begin alu_op = ALU_OR;  state_d = S_WB; end
                    OP_ADDI: begin alu_b_imm = 1'b1; state_d = S_WB; end
                    OP_LD, OP_ST: begin
                        alu_b_imm = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op  = ALU_SUB;
                        pc_load = alu_zero;
                        retire  = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                    end
                    OP_HALT: state_d = S_HALT;
                    // IR changed under us after decode: treat as undefined.
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                if (mem_ready) begin
                    if (opcode == OP_LD) state_d = S_WB;
                    else                 retire  = 1'b1;
                end else if (tmo_q == 4'd1) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    tmo_d = tmo_q - 4'd1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = (opcode == OP_LD);
                retire = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_PAUSE;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_PAUSE;
        end

        if (state_d == S_HALT) halted_d = 1'b1;

        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
            tmo_d = TMO_LOAD;
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: each driven cycle pushes the outputs the
// sequencer must show during that cycle; a negedge monitor pops and compares.
module tb_cpu_control_fsm;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3,
                           W = 3'd4, H = 3'd5, P = 3'd6;

    logic        clk, rst;
    logic [3:0]  opcode;
    logic        alu_zero, mem_ready, run, step;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [1:0]  alu_op;
    logic        alu_b_imm, reg_we, wb_sel, halted, illegal, bus_err;
    logic [2:0]  state_dbg;
    logic [15:0] retired;

    typedef struct {
        logic [2:0]  st;
        logic [10:0] ctrl;
        logic [2:0]  flg;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_cyc    = 0;
    logic [15:0] exp_ret;

    cpu_control_fsm #(.TIMEOUT(15), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .run       (run),
        .step      (step),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_op    (alu_op),
        .alu_b_imm (alu_b_imm),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .halted    (halted),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .state_dbg (state_dbg),
        .retired   (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, n_cyc, obs, exp);
        end
    endtask

    // {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, alu_b_imm, reg_we, wb_sel}
    function automatic logic [10:0] ctrl_exp(input logic [2:0] st, input logic [3:0] op,
                                             input logic rdy, input logic z);
        logic [10:0] c;
        c = '0;
        case (st)
            F: c = {1'b1, 1'b0, 1'b0, rdy, 7'b0};
            D: c = 11'b000_0100_0000;
            E: begin
                case (op)
                    4'h1: c = {6'b0, 2'b00, 3'b000};
                    4'h2: c = {6'b0, 2'b01, 3'b000};
                    4'h3: c = {6'b0, 2'b10, 3'b000};
                    4'h4: c = {6'b0, 2'b11, 3'b000};
                    4'h5, 4'h6, 4'h7: c = {6'b0, 2'b00, 3'b100};
                    4'h8: c = {5'b0, z, 2'b01, 3'b000};
                    4'h9: c = {5'b0, 1'b1, 2'b00, 3'b000};
                    default: c = '0;
                endcase
            end
            M: c = {1'b1, (op == 4'h7), 1'b1, 8'b0};
            W: c = {8'b0, 1'b0, 1'b1, (op == 4'h6)};
            default: c = '0;
        endcase
        return c;
    endfunction

    // One clock of stimulus: inputs already set, push what this cycle must show.
    task automatic cyc(input logic [2:0] st, input logic [2:0] flg);
        exp_t e;
        e.st   = st;
        e.ctrl = ctrl_exp(st, opcode, mem_ready, alu_zero);
        e.flg  = flg;
        e.ret  = exp_ret;
        sb_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer on the non-active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("state", {29'b0, state_dbg}, {29'b0, e.st});
            chk("ctrl", {21'b0, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                         alu_op, alu_b_imm, reg_we, wb_sel}, {21'b0, e.ctrl});
            chk("flags", {29'b0, halted, illegal, bus_err}, {29'b0, e.flg});
            chk("retired", {16'b0, retired}, {16'b0, e.ret});
            n_cyc++;
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0;
        opcode = 4'h0; alu_zero = 1'b0; exp_ret = '0;
        @(posedge clk); #1;
        cyc(P, 3'b000);

        // ADD back-to-back into LD with three wait states in MEM
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 4'h1;
        cyc(P, 3'b000); cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000); cyc(W, 3'b000);
        exp_ret++;
        opcode = 4'h6;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        mem_ready = 1'b0;
        repeat (3) cyc(M, 3'b000);
        mem_ready = 1'b1;
        cyc(M, 3'b000); cyc(W, 3'b000);
        exp_ret++;

        // BEQ taken, BEQ not taken, ST, JMP
        opcode = 4'h8; alu_zero = 1'b1;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        alu_zero = 1'b0;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        opcode = 4'h7;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000); cyc(M, 3'b000);
        exp_ret++;
        opcode = 4'h9;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;

        // remaining register-writing ops
        for (int op = 2; op <= 5; op++) begin
            opcode = 4'(op);
            cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000); cyc(W, 3'b000);
            exp_ret++;
        end

        // run drops mid-instruction: NOP completes, then pause
        opcode = 4'h0;
        cyc(F, 3'b000);
        run = 1'b0;
        cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        cyc(P, 3'b000); cyc(P, 3'b000);

        // single-step: one NOP per rising edge, held step does not repeat
        step = 1'b1;
        cyc(P, 3'b000); cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        cyc(P, 3'b000); cyc(P, 3'b000);
        step = 1'b0;
        cyc(P, 3'b000);
        step = 1'b1;
        cyc(P, 3'b000);
        step = 1'b0;
        cyc(F, 3'b000);
        step = 1'b1;
        cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        cyc(P, 3'b000); cyc(P, 3'b000);
        step = 1'b0;
        cyc(P, 3'b000);

        // mem_ready arrives on the 15th wait cycle of FETCH: no error
        run = 1'b1;
        cyc(P, 3'b000);
        mem_ready = 1'b0;
        repeat (14) cyc(F, 3'b000);
        mem_ready = 1'b1;
        cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;

        // 15 wait cycles without mem_ready: bus error and halt
        mem_ready = 1'b0;
        repeat (15) cyc(F, 3'b000);
        cyc(H, 3'b101); cyc(H, 3'b101);
        rst = 1'b1;
        cyc(H, 3'b101);
        exp_ret = '0;
        cyc(P, 3'b000);
        rst = 1'b0;

        // one NOP, then undefined opcode 0xB
        mem_ready = 1'b1; opcode = 4'h0;
        cyc(P, 3'b000); cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        exp_ret++;
        opcode = 4'hB;
        cyc(F, 3'b000); cyc(D, 3'b000);
        cyc(H, 3'b110); cyc(H, 3'b110);
        rst = 1'b1;
        cyc(H, 3'b110);
        exp_ret = '0;
        cyc(P, 3'b000);
        rst = 1'b0;

        // HALT opcode halts without retiring
        opcode = 4'hF;
        cyc(P, 3'b000); cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        cyc(H, 3'b100); cyc(H, 3'b100);
        rst = 1'b1;
        cyc(H, 3'b100);
        cyc(P, 3'b000);
        rst = 1'b0;

        // reset lands on the same edge ST would have completed
        opcode = 4'h7;
        cyc(P, 3'b000); cyc(F, 3'b000); cyc(D, 3'b000); cyc(E, 3'b000);
        mem_ready = 1'b0;
        cyc(M, 3'b000);
        mem_ready = 1'b1; rst = 1'b1;
        cyc(M, 3'b000);
        cyc(P, 3'b000);
        rst = 1'b0; run = 1'b0;
        cyc(P, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
